// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-producer result queues feeding a round-robin,
// registered CDB broadcast with ROB-flush support.

module cdb_req_queue #(
    parameter int DEPTH = 2,
    parameter int ROB_W = 5,
    parameter int CW    = $clog2(DEPTH) + 1,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [ROB_W-1:0] push_id,
    input  logic [31:0]      push_value,
    output logic [CW-1:0]    count,
    output logic [ROB_W-1:0] head_id,
    output logic [31:0]      head_value
);
    logic [DEPTH-1:0][ROB_W-1:0] mem_id;
    logic [DEPTH-1:0][31:0]      mem_value;
    logic [PW-1:0]               rd_ptr, wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push && !flush) begin
            mem_id[wr_ptr]    <= push_id;
            mem_value[wr_ptr] <= push_value;
        end
    end

    assign head_id    = mem_id[rd_ptr];
    assign head_value = mem_value[rd_ptr];
endmodule

module cdb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DEPTH   = 2,
    parameter int ROB_W   = 5
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     flush_in,
    input  logic [NUM_REQ-1:0]       in_valid,
    output logic [NUM_REQ-1:0]       in_ready,
    input  logic [NUM_REQ*ROB_W-1:0] in_rob_id,
    input  logic [NUM_REQ*32-1:0]    in_value,
    output logic [ROB_W-1:0]         cdb_rob_id,
    output logic [31:0]              cdb_value,
    output logic [1:0]               cdb_src,
    output logic [NUM_REQ-1:0]       pending
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0][CW-1:0]    count;
    logic [NUM_REQ-1:0][ROB_W-1:0] head_id, live_id, cand_id;
    logic [NUM_REQ-1:0][31:0]      head_value, live_value, cand_value;
    logic [NUM_REQ-1:0]            live, cand, push, pop;
    logic [RW-1:0]                 rr_ptr, gnt, rr_next;
    logic                          gnt_vld;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign live_id[i]    = in_rob_id[i*ROB_W +: ROB_W];
        assign live_value[i] = in_value[i*32 +: 32];
        assign in_ready[i]   = count[i] != CW'(DEPTH);
        // rob_id 0 transfers are accepted but never become candidates.
        assign live[i]       = in_valid[i] && in_ready[i] && (live_id[i] != '0);
        assign cand[i]       = (count[i] != '0) || live[i];
        assign cand_id[i]    = (count[i] != '0) ? head_id[i]    : live_id[i];
        assign cand_value[i] = (count[i] != '0) ? head_value[i] : live_value[i];
        assign pop[i]        = gnt_vld && (gnt == RW'(i)) && (count[i] != '0);
        assign push[i]       = live[i] && !(gnt_vld && (gnt == RW'(i)) && (count[i] == '0));
        assign pending[i]    = count[i] != '0;

        cdb_req_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .CW(CW), .PW(PW)) u_q (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .flush      (flush_in),
            .push       (push[i]),
            .pop        (pop[i]),
            .push_id    (live_id[i]),
            .push_value (live_value[i]),
            .count      (count[i]),
            .head_id    (head_id[i]),
            .head_value (head_value[i])
        );
    end

    // Scan from the far end so the candidate nearest rr_ptr wins.
    always_comb begin
        logic [RW:0] idx;
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (RW+1)'(k);
            if (idx >= (RW+1)'(NUM_REQ)) idx = idx - (RW+1)'(NUM_REQ);
            if (cand[idx[RW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt     = idx[RW-1:0];
            end
        end
    end

    assign rr_next = (gnt == RW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr     <= '0;
            cdb_rob_id <= '0;
            cdb_value  <= '0;
            cdb_src    <= '0;
        end else if (flush_in) begin
            cdb_rob_id <= '0;
        end else if (gnt_vld) begin
            rr_ptr     <= rr_next;
            cdb_rob_id <= cand_id[gnt];
            cdb_value  <= cand_value[gnt];
            cdb_src    <= 2'(gnt);
        end else begin
            cdb_rob_id <= '0;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a queue-based reference model.

module tb_cdb_arbiter;
    localparam int NR = 3, DEPTH = 2, RW = 5;

    logic             clk_in = 1'b0, rst_in = 1'b0, flush_in = 1'b0;
    logic [NR-1:0]    in_valid = '0, in_ready, pending;
    logic [NR*RW-1:0] in_rob_id = '0;
    logic [NR*32-1:0] in_value = '0;
    logic [RW-1:0]    cdb_rob_id;
    logic [31:0]      cdb_value;
    logic [1:0]       cdb_src;

    int n_cmp = 0, n_bad = 0;

    // Reference model: one FIFO per producer plus the round-robin pointer.
    logic [RW-1:0] q_id [NR][$];
    logic [31:0]   q_val[NR][$];
    int            rr;
    logic [RW-1:0] e_id;
    logic [31:0]   e_val;
    logic [1:0]    e_src;
    logic [NR-1:0] took = '0;

    cdb_arbiter #(.NUM_REQ(NR), .DEPTH(DEPTH), .ROB_W(RW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_rob_id(in_rob_id),
        .in_value(in_value), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .cdb_src(cdb_src), .pending(pending)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            q_id[i].delete();
            q_val[i].delete();
        end
        rr = 0; e_id = '0; e_val = '0; e_src = '0;
    endtask

    // Predict one clock edge from the current inputs, clock it, compare outputs.
    task automatic step();
        logic [NR-1:0] live, pend;
        logic [RW-1:0] id;
        int g;
        for (int i = 0; i < NR; i++) begin
            check("in_ready", in_ready[i], q_id[i].size() != DEPTH);
            took[i] = in_valid[i] && (q_id[i].size() != DEPTH);
            live[i] = took[i] && (in_rob_id[i*RW +: RW] != '0);
        end
        if (flush_in) begin
            for (int i = 0; i < NR; i++) begin
                q_id[i].delete();
                q_val[i].delete();
            end
            e_id = '0;
        end else begin
            g = -1;
            for (int k = 0; k < NR && g < 0; k++)
                if (q_id[(rr+k)%NR].size() > 0 || live[(rr+k)%NR]) g = (rr + k) % NR;
            for (int i = 0; i < NR; i++) begin
                id = in_rob_id[i*RW +: RW];
                if (i == g && q_id[i].size() > 0) begin
                    e_id  = q_id[i].pop_front();
                    e_val = q_val[i].pop_front();
                    if (live[i]) begin
                        q_id[i].push_back(id);
                        q_val[i].push_back(in_value[i*32 +: 32]);
                    end
                end else if (i == g) begin
                    e_id  = id;
                    e_val = in_value[i*32 +: 32];
                end else if (live[i]) begin
                    q_id[i].push_back(id);
                    q_val[i].push_back(in_value[i*32 +: 32]);
                end
            end
            if (g >= 0) begin
                e_src = 2'(g);
                rr = (g + 1) % NR;
            end else begin
                e_id = '0;
            end
        end
        @(posedge clk_in);
        #1;
        for (int i = 0; i < NR; i++) pend[i] = q_id[i].size() != 0;
        check("cdb_rob_id", cdb_rob_id, e_id);
        if (e_id != '0) begin
            check("cdb_value", cdb_value, e_val);
            check("cdb_src", cdb_src, e_src);
        end
        check("pending", pending, pend);
    endtask

    // Producers hold a result until it transfers; otherwise draw a new one.
    task automatic drive_rand(input int pv, input bit zero_ok);
        for (int i = 0; i < NR; i++) begin
            if (!(in_valid[i] && !took[i])) begin
                in_valid[i] = $urandom_range(99) < pv;
                in_rob_id[i*RW +: RW] = zero_ok ? RW'($urandom_range(31)) : RW'($urandom_range(31, 1));
                in_value[i*32 +: 32] = $urandom;
            end
        end
    endtask

    task automatic set_in(input int i, input bit v, input int id, input logic [31:0] val);
        in_valid[i] = v;
        in_rob_id[i*RW +: RW] = RW'(id);
        in_value[i*32 +: 32] = val;
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_id", cdb_rob_id, 0);
        check("rst_pending", pending, 0);
        check("rst_ready", in_ready, 3'b111);
        rst_in = 1'b1;

        // Single ALU result, one-cycle latency then idle.
        set_in(0, 1, 3, 32'h11);
        step();
        check("t1_id", cdb_rob_id, 3);
        check("t1_val", cdb_value, 32'h11);
        check("t1_src", cdb_src, 0);
        in_valid = '0;
        step();
        check("t1_idle", cdb_rob_id, 0);

        // All producers busy: sequential ids per source, rotation and backpressure.
        for (int i = 0; i < NR; i++) set_in(i, 1, 1 + 3*i, 32'h100 + i);
        for (int c = 0; c < 12; c++) begin
            step();
            for (int i = 0; i < NR; i++)
                if (took[i]) set_in(i, 1, in_rob_id[i*RW +: RW] + 1, in_value[i*32 +: 32] + 32'h10);
        end

        // Flush with queued and incoming results; nothing may surface afterwards.
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        check("fl_pending", pending, 0);
        check("fl_ready", in_ready, 3'b111);
        in_valid = '0;
        for (int c = 0; c < 3; c++) step();

        // rob_id 0 is accepted and dropped.
        set_in(2, 1, 0, 32'hdead);
        step();
        check("z_pending", pending[2], 0);
        check("z_ready", in_ready[2], 1);
        check("z_id", cdb_rob_id, 0);
        in_valid = '0;

        // Async reset while queues hold data, with rr pointer moved off 0.
        for (int i = 0; i < NR; i++) set_in(i, 1, 20 + i, 32'h200 + i);
        step();
        step();
        for (int c = 0; c < 4 && rr == 0; c++) step();
        #2 rst_in = 1'b0;
        #1;
        check("ar_id", cdb_rob_id, 0);
        check("ar_val", cdb_value, 0);
        check("ar_src", cdb_src, 0);
        check("ar_pending", pending, 0);
        check("ar_ready", in_ready, 3'b111);
        model_reset();
        took = '0;
        #1 rst_in = 1'b1;
        for (int i = 0; i < NR; i++) set_in(i, 1, 25 + i, 32'h300 + i);
        step();
        check("ar_rr", cdb_src, 0);
        check("ar_first", cdb_rob_id, 25);
        in_valid = '0;

        // Random traffic with occasional flushes.
        for (int c = 0; c < 3000; c++) begin
            drive_rand(60, c % 7 == 0);
            flush_in = ($urandom_range(19) == 0);
            step();
        end
        flush_in = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
